// File: rtl/chroni_cpu_reader.sv
// chroni CPU read-back port: status, scanline, palette and VRAM reads.
// VRAM goes through a one-byte prefetch buffer, palette through a two-stage fetch.
module chroni_cpu_reader #(
   parameter int VRAM_AW = 17,
   parameter int PAL_AW  = 8
) (
   input  logic               sys_clk,
   input  logic               reset_n,
   input  logic [15:0]        cpu_addr,
   input  logic               cpu_rd_en,
   input  logic               cpu_wr_en,
   input  logic [7:0]         cpu_wr_data,
   output logic [7:0]         cpu_rd_data,
   output logic               cpu_wait,
   output logic               vram_rd_req,
   output logic [VRAM_AW-1:0] vram_rd_addr,
   input  logic               vram_rd_gnt,
   input  logic               vram_rd_valid,
   input  logic [7:0]         vram_rd_data,
   output logic [PAL_AW-1:0]  palette_rd_addr,
   input  logic [15:0]        palette_rd_data,
   input  logic               vga_vblank,
   input  logic [9:0]         vga_scanline
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]         state;
   logic [VRAM_AW-1:0] ptr;
   logic [VRAM_AW-1:0] ptr_nx;
   logic [VRAM_AW-1:0] req_addr;
   logic               stale;
   logic               pf_valid;
   logic [7:0]         pf_data;

   logic [PAL_AW-1:0]  idx;
   logic               phase;
   logic               pal_valid;
   logic               pal_s1;
   logic               pal_s2;
   logic [15:0]        pal_buf;

   logic       sel;
   logic [3:0] off;
   logic       rd_acc;
   logic       wr_hit;
   logic       ptr_wr;
   logic       pal_wr;
   logic       rd_vram;
   logic       rd_pal;
   logic [7:0] rd_mux;

   assign sel = (cpu_addr[15:4] == 12'h900);
   assign off = cpu_addr[3:0];

   assign cpu_wait = cpu_rd_en & sel &
                     (((off == 4'hF) & ~pf_valid) |
                      ((off == 4'hB) & ~pal_valid));

   assign rd_acc  = cpu_rd_en & sel & ~cpu_wait;
   assign wr_hit  = cpu_wr_en & sel;
   assign ptr_wr  = wr_hit & ((off == 4'hC) | (off == 4'hD) | (off == 4'hE));
   assign pal_wr  = wr_hit & (off == 4'hA);
   assign rd_vram = rd_acc & (off == 4'hF);
   assign rd_pal  = rd_acc & (off == 4'hB);

   assign vram_rd_req     = (state == ST_REQ);
   assign vram_rd_addr    = req_addr;
   assign palette_rd_addr = idx;

   always_comb begin
      ptr_nx = ptr;
      if (wr_hit) begin
         case (off)
            4'hC:    ptr_nx[7:0]  = cpu_wr_data;
            4'hD:    ptr_nx[15:8] = cpu_wr_data;
            4'hE:    ptr_nx[16]   = cpu_wr_data[0];
            default: ptr_nx = ptr;
         endcase
      end
   end

   always_comb begin
      rd_mux = 8'h00;
      case (off)
         4'h0:    rd_mux = {vga_vblank, 5'b0, pal_valid, pf_valid};
         4'h1:    rd_mux = vga_scanline[7:0];
         4'h2:    rd_mux = {6'b0, vga_scanline[9:8]};
         4'hB:    rd_mux = phase ? pal_buf[15:8] : pal_buf[7:0];
         4'hF:    rd_mux = pf_data;
         default: rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         cpu_rd_data <= 8'h00;
      end else if (rd_acc) begin
         cpu_rd_data <= rd_mux;
      end
   end

   // The request address only moves on (re)entry to REQ, so late pointer
   // writes mark the fetch stale and are picked up on the restart.
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         req_addr <= '0;
         stale    <= 1'b0;
         pf_valid <= 1'b0;
         pf_data  <= 8'h00;
      end else begin
         if (ptr_wr) begin
            ptr      <= ptr_nx;
            pf_valid <= 1'b0;
         end
         if (rd_vram) begin
            ptr      <= ptr + 1'b1;
            req_addr <= ptr + 1'b1;
            pf_valid <= 1'b0;
            state    <= ST_REQ;
         end
         case (state)
            ST_IDLE: begin
               if (ptr_wr) begin
                  state    <= ST_REQ;
                  req_addr <= ptr_nx;
               end
            end
            ST_REQ: begin
               if (ptr_wr) stale <= 1'b1;
               if (vram_rd_gnt) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (vram_rd_valid) begin
                  if (stale | ptr_wr) begin
                     stale    <= 1'b0;
                     state    <= ST_REQ;
                     req_addr <= ptr_nx;
                  end else begin
                     pf_data  <= vram_rd_data;
                     pf_valid <= 1'b1;
                     state    <= ST_IDLE;
                  end
               end else if (ptr_wr) begin
                  stale <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // pal_s1/pal_s2 track the synchronous palette read latency
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         idx       <= '0;
         phase     <= 1'b0;
         pal_valid <= 1'b0;
         pal_s1    <= 1'b0;
         pal_s2    <= 1'b0;
         pal_buf   <= 16'h0000;
      end else begin
         pal_s1 <= 1'b0;
         pal_s2 <= pal_s1;
         if (pal_s2) begin
            pal_buf   <= palette_rd_data;
            pal_valid <= 1'b1;
         end
         if (pal_wr) begin
            idx       <= cpu_wr_data[PAL_AW-1:0];
            phase     <= 1'b0;
            pal_valid <= 1'b0;
            pal_s1    <= 1'b1;
            pal_s2    <= 1'b0;
         end else if (rd_pal) begin
            if (!phase) begin
               phase <= 1'b1;
            end else begin
               phase     <= 1'b0;
               idx       <= idx + 1'b1;
               pal_valid <= 1'b0;
               pal_s1    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_chroni_cpu_reader.sv
// Directed bench for chroni_cpu_reader with behavioural VRAM arbiter
// and synchronous palette RAM models.
module tb_chroni_cpu_reader;

   logic        sys_clk = 1'b0;
   logic        reset_n;
   logic [15:0] cpu_addr;
   logic        cpu_rd_en;
   logic        cpu_wr_en;
   logic [7:0]  cpu_wr_data;
   logic [7:0]  cpu_rd_data;
   logic        cpu_wait;
   logic        vram_rd_req;
   logic [16:0] vram_rd_addr;
   logic        vram_rd_gnt;
   logic        vram_rd_valid = 1'b0;
   logic [7:0]  vram_rd_data = 8'h00;
   logic [7:0]  palette_rd_addr;
   logic [15:0] palette_rd_data = 16'h0000;
   logic        vga_vblank;
   logic [9:0]  vga_scanline;

   logic [7:0]  vmem [0:131071];
   logic [15:0] pmem [0:255];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int gnt_from = 0;
   int reqs = 0;
   int lat = 0;
   logic [16:0] lat_addr = '0;

   chroni_cpu_reader dut (
      .sys_clk         (sys_clk),
      .reset_n         (reset_n),
      .cpu_addr        (cpu_addr),
      .cpu_rd_en       (cpu_rd_en),
      .cpu_wr_en       (cpu_wr_en),
      .cpu_wr_data     (cpu_wr_data),
      .cpu_rd_data     (cpu_rd_data),
      .cpu_wait        (cpu_wait),
      .vram_rd_req     (vram_rd_req),
      .vram_rd_addr    (vram_rd_addr),
      .vram_rd_gnt     (vram_rd_gnt),
      .vram_rd_valid   (vram_rd_valid),
      .vram_rd_data    (vram_rd_data),
      .palette_rd_addr (palette_rd_addr),
      .palette_rd_data (palette_rd_data),
      .vga_vblank      (vga_vblank),
      .vga_scanline    (vga_scanline)
   );

   always #5 sys_clk = ~sys_clk;

   assign vram_rd_gnt = vram_rd_req && (cyc >= gnt_from);

   // arbiter: data returns as a one-cycle pulse two cycles after the grant
   always @(posedge sys_clk) begin
      cyc <= cyc + 1;
      vram_rd_valid <= 1'b0;
      if (lat > 0) begin
         lat <= lat - 1;
         if (lat == 1) begin
            vram_rd_valid <= 1'b1;
            vram_rd_data  <= vmem[lat_addr];
         end
      end
      if (vram_rd_req && vram_rd_gnt) begin
         lat      <= 2;
         lat_addr <= vram_rd_addr;
         reqs     <= reqs + 1;
      end
      palette_rd_data <= pmem[palette_rd_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic cpu_write(input logic [3:0] o, input logic [7:0] d);
      @(negedge sys_clk);
      cpu_addr    = {12'h900, o};
      cpu_wr_data = d;
      cpu_wr_en   = 1'b1;
      @(negedge sys_clk);
      cpu_wr_en   = 1'b0;
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [7:0] d,
                           output int stalls);
      @(negedge sys_clk);
      cpu_addr  = a;
      cpu_rd_en = 1'b1;
      stalls    = 0;
      #1;
      while (cpu_wait === 1'b1 && stalls < 300) begin
         @(negedge sys_clk);
         #1;
         stalls++;
      end
      if (stalls >= 300) begin
         vectors++;
         miscompares++;
         $error("FAIL read_timeout: observed stall %0d expected <300", stalls);
      end
      @(posedge sys_clk);
      #1;
      d = cpu_rd_data;
      cpu_rd_en = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      int st;
      int wsum;
      int r0;
      logic stable;
      logic [7:0] exp_map [0:15];

      for (int i = 0; i < 131072; i++) vmem[i] = 8'h00;
      for (int i = 0; i < 256; i++) pmem[i] = 16'h0000;
      vmem[17'h1FFFE] = 8'h11;
      vmem[17'h1FFFF] = 8'h22;
      vmem[17'h00000] = 8'h33;
      vmem[17'h00001] = 8'h44;
      vmem[17'h00100] = 8'hAA;
      vmem[17'h00200] = 8'hBB;
      vmem[17'h00205] = 8'h5A;
      pmem[8'hFF] = 16'h1234;
      pmem[8'h00] = 16'h5678;

      reset_n      = 1'b0;
      cpu_addr     = 16'h0000;
      cpu_rd_en    = 1'b0;
      cpu_wr_en    = 1'b0;
      cpu_wr_data  = 8'h00;
      vga_vblank   = 1'b1;
      vga_scanline = 10'h2A5;
      idle(3);
      reset_n = 1'b1;
      idle(1);

      check("rst_rd_data", cpu_rd_data, 8'h00);
      check("rst_wait", cpu_wait, 1'b0);
      check("rst_req", vram_rd_req, 1'b0);
      check("rst_vaddr", vram_rd_addr, 17'h0);
      check("rst_paddr", palette_rd_addr, 8'h00);

      for (int i = 0; i < 16; i++) exp_map[i] = 8'h00;
      exp_map[1] = 8'hA5;
      exp_map[2] = 8'h02;
      wsum = 0;
      for (int i = 1; i < 15; i++) begin
         if (i != 11) begin
            cpu_read({12'h900, 4'(i)}, d, st);
            wsum += st;
            check($sformatf("map_%0h", i), d, exp_map[i]);
         end
      end
      cpu_read(16'h9000, d, st);
      wsum += st;
      check("status_rst", d, 8'h80);
      check("map_no_wait", wsum, 0);
      cpu_read(16'h8000, d, st);
      check("out_of_window_hold", d, 8'h80);

      @(negedge sys_clk);
      cpu_addr  = 16'h900F;
      cpu_rd_en = 1'b1;
      #1 check("wait_vram_empty", cpu_wait, 1'b1);
      cpu_addr  = 16'h900B;
      #1 check("wait_pal_empty", cpu_wait, 1'b1);
      cpu_rd_en = 1'b0;

      cpu_write(4'hE, 8'h01);
      cpu_write(4'hD, 8'hFF);
      cpu_write(4'hC, 8'hFE);
      cpu_read(16'h900F, d, st);
      check("vram_1fffe", d, 8'h11);
      check("vram_1fffe_wait", st > 0, 1'b1);
      cpu_read(16'h900F, d, st);
      check("vram_1ffff", d, 8'h22);
      check("vram_1ffff_wait", st > 0, 1'b1);
      cpu_read(16'h900F, d, st);
      check("vram_wrap_0", d, 8'h33);
      check("vram_wrap_0_wait", st > 0, 1'b1);
      cpu_read(16'h900F, d, st);
      check("vram_1", d, 8'h44);
      check("vram_1_wait", st > 0, 1'b1);

      idle(8);
      cpu_write(4'hC, 8'h00);
      idle(8);
      r0 = reqs;
      cpu_write(4'hD, 8'h01);
      idle(1);
      cpu_write(4'hD, 8'h02);
      cpu_read(16'h900F, d, st);
      check("stale_data", d, 8'hBB);
      check("stale_reqs", reqs - r0, 2);

      idle(8);
      cpu_write(4'hC, 8'h05);
      gnt_from = cyc + 10;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (vram_rd_req !== 1'b1 || vram_rd_addr !== 17'h00205) stable = 1'b0;
         @(negedge sys_clk);
      end
      check("hold_req_stable", stable, 1'b1);
      cpu_read(16'h900F, d, st);
      check("hold_data", d, 8'h5A);
      check("hold_stalled", st > 0, 1'b1);

      cpu_write(4'hA, 8'hFF);
      cpu_read(16'h900B, d, st);
      check("pal_ff_lo", d, 8'h34);
      check("pal_ff_lo_wait", st > 0, 1'b1);
      cpu_read(16'h900B, d, st);
      check("pal_ff_hi", d, 8'h12);
      check("pal_wrap_addr", palette_rd_addr, 8'h00);
      cpu_read(16'h900B, d, st);
      check("pal_00_lo", d, 8'h78);
      check("pal_00_lo_wait", st > 0, 1'b1);
      cpu_read(16'h900B, d, st);
      check("pal_00_hi", d, 8'h56);

      idle(8);
      cpu_write(4'hC, 8'h10);
      idle(1);
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      idle(3);
      check("rst2_rd_data", cpu_rd_data, 8'h00);
      check("rst2_req", vram_rd_req, 1'b0);
      check("rst2_vaddr", vram_rd_addr, 17'h0);
      check("rst2_paddr", palette_rd_addr, 8'h00);
      check("rst2_wait", cpu_wait, 1'b0);
      vga_vblank = 1'b0;
      cpu_read(16'h9000, d, st);
      check("rst2_status", d, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
